reg_wb_arbiter: RTL

- Writeback arbiter that drives the register file's single write port (A3/WD3/WE3).
- Merges two writeback sources:
  - the in-order pipeline writeback, which is never back-pressured;
  - a long-latency source (load/store unit or multi-cycle ALU) on a valid/ready handshake, buffered in a small FIFO.
- Also reports which destination registers still have writes pending, for hazard detection.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/wb_fifo.sv | 62 ++++++
 rtl/reg_wb_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the writeback path.
//   reg_addr_t : 5-bit register-file address
//   word_t     : 32-bit data word
//   wb_entry_t : one pending writeback (destination + data)
//   REG_ZERO   : hard-wired zero register; writes to it are dropped
package cpu_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      reg_addr_t rd;
      word_t     data;
   } wb_entry_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries for the long-latency source.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (discards contents)
//   push, din       enqueue din when push=1 (caller guarantees !full)
//   pop, head       head is the oldest entry; pop=1 retires it (caller guarantees !empty)
//   full, empty     occupancy flags
//   ent_valid       per-slot valid, for pending-write lookup
//   ent_rd          per-slot destination register
import cpu_pkg::*;

module wb_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  wb_entry_t                   din,
   input  logic                        pop,
   output wb_entry_t                   head,
   output logic                        full,
   output logic                        empty,
   output logic [DEPTH-1:0]            ent_valid,
   output logic [DEPTH-1:0][4:0]       ent_rd
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // One extra pointer bit distinguishes full from empty.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] count;
   wb_entry_t   mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // A slot is live when its distance from the read pointer is below the occupancy.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      logic [AW-1:0] offs;
      assign offs         = AW'(g) - rd_ptr[AW-1:0];
      assign ent_valid[g] = ({1'b0, offs} < count);
      assign ent_rd[g]    = mem[g].rd;
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the register file's single write port (A3/WD3/WE3).
// The pipeline writeback always wins; long-latency results wait in a FIFO and
// retire in arrival order whenever the pipeline is idle. A starve counter
// requests a pipeline bubble when the FIFO head keeps losing.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   pipe_we, pipe_rd, pipe_data     pipeline writeback (never back-pressured)
//   lsu_valid/lsu_ready, lsu_rd,
//   lsu_data                        long-latency result handshake
//   rf_we, rf_a3, rf_wd3            registered register-file write port
//   pipe_stall                      bubble request to the hazard unit
//   q_rd, q_pending                 pending-write query (combinational)
//   fwd_hit, fwd_data               only with REG_WB_FWD_EN: bypass of the
//                                   write currently on rf_*
import cpu_pkg::*;

module reg_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        rf_we,
   output logic [4:0]  rf_a3,
   output logic [31:0] rf_wd3,
   output logic        pipe_stall,
   input  logic [4:0]  q_rd,
   output logic        q_pending
`ifdef REG_WB_FWD_EN
  ,output logic        fwd_hit,
   output logic [31:0] fwd_data
`endif
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   logic                    pipe_req;
   logic                    push;
   logic                    pop;
   logic                    full;
   logic                    empty;
   wb_entry_t               head;
   wb_entry_t               din;
   logic [DEPTH-1:0]        ent_valid;
   logic [DEPTH-1:0][4:0]   ent_rd;
   logic [SW-1:0]           starve_cnt;
   logic [SW-1:0]           starve_nxt;
   logic                    hit;

   // Writes to r0 are no request at all, so the FIFO may use that slot.
   assign pipe_req  = pipe_we && (pipe_rd != REG_ZERO);
   assign lsu_ready = rst_n && !full;
   assign push      = lsu_valid && lsu_ready && (lsu_rd != REG_ZERO);
   assign pop       = !pipe_req && !empty;
   assign din       = '{rd: lsu_rd, data: lsu_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .din       (din),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd)
   );

   always_comb begin
      starve_nxt = starve_cnt;
      if (empty || pop)
         starve_nxt = '0;
      else if (starve_cnt != STARVE_MAX)
         starve_nxt = starve_cnt + STARVE_ONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we      <= 1'b0;
         rf_a3      <= '0;
         rf_wd3     <= '0;
         starve_cnt <= '0;
         pipe_stall <= 1'b0;
      end else begin
         starve_cnt <= starve_nxt;
         pipe_stall <= (starve_nxt == STARVE_MAX);
         if (pipe_req) begin
            rf_we  <= 1'b1;
            rf_a3  <= pipe_rd;
            rf_wd3 <= pipe_data;
         end else if (pop) begin
            rf_we  <= 1'b1;
            rf_a3  <= head.rd;
            rf_wd3 <= head.data;
         end else begin
            rf_we  <= 1'b0;
         end
      end
   end

   // Pending = still queued, or on the write port this cycle.
   always_comb begin
      hit = rf_we && (rf_a3 == q_rd);
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && (ent_rd[i] == q_rd)) hit = 1'b1;
      end
      q_pending = hit && (q_rd != REG_ZERO);
   end

`ifdef REG_WB_FWD_EN
   assign fwd_hit  = rf_we && (rf_a3 == q_rd) && (q_rd != REG_ZERO);
   assign fwd_data = rf_wd3;
`endif

endmodule
